// File: rtl/sync_filter_bank.sv
`default_nettype none
// ============================================================================
// sync_filter_bank : per-channel synchroniser chain, debounce filter and
//                    registered rise/fall/any-change edge pulses.
// Revision 1.0 - initial release
// ============================================================================
module sync_filter_bank #(
    parameter int CHANNELS      = 4,
    parameter int STAGES        = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] async_in,
    input  logic                filter_en,
    output logic [CHANNELS-1:0] data_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic                any_change
);

    localparam int                 c_CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(FILTER_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [CHANNELS-1:0] w_rise_d;
    logic [CHANNELS-1:0] w_fall_d;
    logic                any_change_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [STAGES-1:0]  sync_q;
        logic [c_CNT_W-1:0] cnt_q;
        logic [c_CNT_W-1:0] cnt_d;
        logic               out_q;
        logic               out_d;
        logic               rise_q;
        logic               fall_q;
        logic               w_s;

        assign w_s = sync_q[STAGES-1];

        // A mismatch must persist for FILTER_CYCLES consecutive cycles; any
        // return to the current level drops the count back to zero.
        always_comb begin
            out_d = out_q;
            cnt_d = '0;
            if (!filter_en) begin
                out_d = w_s;
            end else if (w_s != out_q) begin
                if (cnt_q == c_LAST) begin
                    out_d = w_s;
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
            end
        end

        assign w_rise_d[i] = out_d & ~out_q;
        assign w_fall_d[i] = ~out_d & out_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= '0;
                cnt_q  <= '0;
                out_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[STAGES-2:0], async_in[i]};
                cnt_q  <= cnt_d;
                out_q  <= out_d;
                rise_q <= w_rise_d[i];
                fall_q <= w_fall_d[i];
            end
        end

        assign data_out[i]   = out_q;
        assign rise_pulse[i] = rise_q;
        assign fall_pulse[i] = fall_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            any_change_q <= 1'b0;
        end else begin
            any_change_q <= |(w_rise_d | w_fall_d);
        end
    end

    assign any_change = any_change_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_filter_bank.sv
`default_nettype none
// ============================================================================
// tb_sync_filter_bank : directed vector table for the default configuration
//                       plus a hand sequence on an 8-channel, 3-stage,
//                       1-cycle-filter instance.
// Revision 1.0 - initial release
// ============================================================================
module tb_sync_filter_bank;

    logic       clk;
    logic       rst;
    logic       filter_en;
    logic [3:0] async_in;
    logic [3:0] data_out;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic       any_change;

    logic [7:0] async8;
    logic [7:0] data8;
    logic [7:0] rise8;
    logic [7:0] fall8;
    logic       any8;

    int n_pass;
    int n_total;

    sync_filter_bank #(
        .CHANNELS      (4),
        .STAGES        (2),
        .FILTER_CYCLES (4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .async_in   (async_in),
        .filter_en  (filter_en),
        .data_out   (data_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .any_change (any_change)
    );

    sync_filter_bank #(
        .CHANNELS      (8),
        .STAGES        (3),
        .FILTER_CYCLES (1)
    ) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .async_in   (async8),
        .filter_en  (filter_en),
        .data_out   (data8),
        .rise_pulse (rise8),
        .fall_pulse (fall8),
        .any_change (any8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       fe;
        logic [3:0] ain;
        logic [3:0] dout;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       any;
    } vec_t;

    vec_t vecs[$];

    task automatic addn(input int n, input logic r, input logic fe, input logic [3:0] ain,
                        input logic [3:0] dout, input logic [3:0] rise,
                        input logic [3:0] fall, input logic any);
        vec_t v;
        v.rst  = r;
        v.fe   = fe;
        v.ain  = ain;
        v.dout = dout;
        v.rise = rise;
        v.fall = fall;
        v.any  = any;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] got,
                       input logic [7:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        filter_en = 1'b1;
        async_in  = 4'h0;
        async8    = 8'h00;

        // reset held with inputs high, then release: rise after 5 edges
        addn(3, 1, 1, 4'hF, 4'h0, 4'h0, 4'h0, 0);
        addn(5, 0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 0);
        addn(1, 0, 1, 4'hF, 4'hF, 4'hF, 4'h0, 1);
        addn(1, 0, 1, 4'hF, 4'hF, 4'h0, 4'h0, 0);
        // channel 0 low then high again, 5-edge latency each way
        addn(5, 0, 1, 4'hE, 4'hF, 4'h0, 4'h0, 0);
        addn(1, 0, 1, 4'hE, 4'hE, 4'h0, 4'h1, 1);
        addn(1, 0, 1, 4'hE, 4'hE, 4'h0, 4'h0, 0);
        addn(5, 0, 1, 4'hF, 4'hE, 4'h0, 4'h0, 0);
        addn(1, 0, 1, 4'hF, 4'hF, 4'h1, 4'h0, 1);
        addn(1, 0, 1, 4'hF, 4'hF, 4'h0, 4'h0, 0);
        // all channels back low
        addn(5, 0, 1, 4'h0, 4'hF, 4'h0, 4'h0, 0);
        addn(1, 0, 1, 4'h0, 4'h0, 4'h0, 4'hF, 1);
        addn(1, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        // 3-cycle glitch on channel 2 rejected
        addn(3, 0, 1, 4'h4, 4'h0, 4'h0, 4'h0, 0);
        addn(7, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        // 4-cycle pulse accepted; rise and fall 4 edges apart
        addn(4, 0, 1, 4'h4, 4'h0, 4'h0, 4'h0, 0);
        addn(1, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        addn(1, 0, 1, 4'h0, 4'h4, 4'h4, 4'h0, 1);
        addn(3, 0, 1, 4'h0, 4'h4, 4'h0, 4'h0, 0);
        addn(1, 0, 1, 4'h0, 4'h0, 4'h0, 4'h4, 1);
        addn(1, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        // bypass: channel 1 toggled every cycle, followed with 2-cycle latency
        addn(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        addn(1, 0, 0, 4'h2, 4'h0, 4'h0, 4'h0, 0);
        addn(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        addn(1, 0, 0, 4'h2, 4'h2, 4'h2, 4'h0, 1);
        addn(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h2, 1);
        addn(1, 0, 0, 4'h2, 4'h2, 4'h2, 4'h0, 1);
        addn(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h2, 1);
        addn(1, 0, 0, 4'h0, 4'h2, 4'h2, 4'h0, 1);
        addn(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h2, 1);
        addn(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        // channel 3 counting, reset at count 2, then full latency again
        addn(4, 0, 1, 4'h8, 4'h0, 4'h0, 4'h0, 0);
        addn(1, 1, 1, 4'h8, 4'h0, 4'h0, 4'h0, 0);
        addn(5, 0, 1, 4'h8, 4'h0, 4'h0, 4'h0, 0);
        addn(1, 0, 1, 4'h8, 4'h8, 4'h8, 4'h0, 1);
        addn(1, 0, 1, 4'h8, 4'h8, 4'h0, 4'h0, 0);

        foreach (vecs[i]) begin
            rst       = vecs[i].rst;
            filter_en = vecs[i].fe;
            async_in  = vecs[i].ain;
            tick();
            chk("data_out",   i, {4'h0, data_out},   {4'h0, vecs[i].dout});
            chk("rise_pulse", i, {4'h0, rise_pulse}, {4'h0, vecs[i].rise});
            chk("fall_pulse", i, {4'h0, fall_pulse}, {4'h0, vecs[i].fall});
            chk("any_change", i, {7'h0, any_change}, {7'h0, vecs[i].any});
        end

        // 8-channel instance: every channel changes together, accepted 3 edges later
        rst       = 1'b0;
        filter_en = 1'b1;
        async8    = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("w8_data_wait", k, data8, 8'h00);
            chk("w8_any_wait",  k, {7'h0, any8}, 8'h00);
        end
        tick();
        chk("w8_data_rise", 0, data8, 8'hA5);
        chk("w8_rise",      0, rise8, 8'hA5);
        chk("w8_fall",      0, fall8, 8'h00);
        chk("w8_any",       0, {7'h0, any8}, 8'h01);
        tick();
        chk("w8_rise_end",  0, rise8, 8'h00);
        chk("w8_any_end",   0, {7'h0, any8}, 8'h00);

        async8 = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("w8_data_hold", k, data8, 8'hA5);
        end
        tick();
        chk("w8_data_swap", 1, data8, 8'h5A);
        chk("w8_rise_swap", 1, rise8, 8'h5A);
        chk("w8_fall_swap", 1, fall8, 8'hA5);
        chk("w8_any_swap",  1, {7'h0, any8}, 8'h01);
        tick();
        chk("w8_pulse_end", 1, rise8 | fall8, 8'h00);
        chk("w8_any_end2",  1, {7'h0, any8}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
